// File: rtl/sdram_wb_write_feeder.sv
// Wishbone write front end for the SDRAM write path: packs accepted writes into
// {dqm,data} FIFO words and owns sdram_write's en/address burst handshake.
module sdram_wb_write_feeder #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_fifo_wr,
    output logic [35:0] o_fifo_data,
    input  logic        i_fifo_full,
    input  logic        i_fifo_empty,
    output logic        o_wr_en,
    output logic [21:0] o_wr_address,
    input  logic        i_wr_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_STREAM  = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int            TW         = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   next_adr_q, next_adr_d;
    logic          ready_seen_q, ready_seen_d;
    logic          ack_q, ack_d;
    logic          fifo_wr_q, fifo_wr_d;
    logic [35:0]   fifo_data_q, fifo_data_d;
    logic          wr_en_q, wr_en_d;
    logic [21:0]   wr_address_q, wr_address_d;

    logic wr_req;
    logic can_take;
    logic accept;

    // The request still on the bus during the ack cycle is the one just taken,
    // so it must neither be accepted again nor be mistaken for an address break.
    assign wr_req   = i_wb_cyc & i_wb_stb & i_wb_we & ~ack_q;
    assign can_take = wr_req & ~i_fifo_full;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        timer_d      = timer_q;
        next_adr_d   = next_adr_q;
        ready_seen_d = ready_seen_q;
        wr_en_d      = wr_en_q;
        wr_address_d = wr_address_q;
        fifo_data_d  = fifo_data_q;
        accept       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (can_take && i_wr_ready) begin
                    accept       = 1'b1;
                    wr_en_d      = 1'b1;
                    wr_address_d = i_wb_adr[22:1];
                    next_adr_d   = i_wb_adr + 32'd4;
                    timer_d      = '0;
                    state_d      = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (wr_req && (i_wb_adr != next_adr_q)) begin
                    state_d = ST_DRAIN;
                end else if (can_take) begin
                    accept     = 1'b1;
                    next_adr_d = next_adr_q + 32'd4;
                    timer_d    = '0;
                end else if (i_fifo_full) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    if (i_fifo_empty) state_d = ST_DRAIN;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (i_fifo_empty) begin
                    wr_en_d      = 1'b0;
                    ready_seen_d = 1'b0;
                    state_d      = ST_RELEASE;
                end
            end
            default: begin
                // sdram_write updates ready on negedge; require two samples in a row.
                ready_seen_d = i_wr_ready;
                if (i_wr_ready && ready_seen_q) begin
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase

        ack_d     = accept;
        fifo_wr_d = accept;
        if (accept) fifo_data_d = {~i_wb_sel, i_wb_dat};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            next_adr_q   <= '0;
            ready_seen_q <= 1'b0;
            ack_q        <= 1'b0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            next_adr_q   <= next_adr_d;
            ready_seen_q <= ready_seen_d;
            ack_q        <= ack_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
        end
    end

    assign o_wb_ack     = ack_q;
    assign o_fifo_wr    = fifo_wr_q;
    assign o_fifo_data  = fifo_data_q;
    assign o_wr_en      = wr_en_q;
    assign o_wr_address = wr_address_q;

endmodule

// File: tb/tb_sdram_wb_write_feeder.sv
// Bench for sdram_wb_write_feeder: directed scenarios with literal expectations,
// then randomized Wishbone traffic checked every cycle against a burst-level model.
module tb_sdram_wb_write_feeder;

    localparam int IDLE_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        fifo_full = 1'b0, fifo_empty = 1'b1, wr_ready = 1'b1;
    logic        wb_ack, fifo_wr, wr_en;
    logic [35:0] fifo_data;
    logic [21:0] wr_address;

    sdram_wb_write_feeder #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wb_cyc     (wb_cyc),
        .i_wb_stb     (wb_stb),
        .i_wb_we      (wb_we),
        .i_wb_adr     (wb_adr),
        .i_wb_dat     (wb_dat),
        .i_wb_sel     (wb_sel),
        .o_wb_ack     (wb_ack),
        .o_fifo_wr    (fifo_wr),
        .o_fifo_data  (fifo_data),
        .i_fifo_full  (fifo_full),
        .i_fifo_empty (fifo_empty),
        .o_wr_en      (wr_en),
        .o_wr_address (wr_address),
        .i_wr_ready   (wr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Burst-level model: a burst is described by its start address and beat count;
    // the next sequential address is start + 4*beats.
    logic        m_ack, m_wr_en, m_closing, m_settling;
    logic [21:0] m_addr;
    logic [35:0] m_data;
    logic [31:0] m_start;
    int          m_beats, m_idle, m_streak;

    task automatic model_reset();
        m_ack = 0; m_wr_en = 0; m_closing = 0; m_settling = 0;
        m_addr = '0; m_data = '0; m_start = '0;
        m_beats = 0; m_idle = 0; m_streak = 0;
    endtask

    // Predict outputs after the coming posedge from the inputs now on the bus.
    task automatic model_step();
        logic fresh, took;
        logic [31:0] want;
        if (!rst_n) return;
        fresh = wb_cyc && wb_stb && wb_we && !m_ack;
        took  = 1'b0;
        if (!m_wr_en && !m_settling) begin
            if (fresh && !fifo_full && wr_ready) begin
                took = 1'b1; m_wr_en = 1'b1; m_addr = wb_adr[22:1];
                m_start = wb_adr; m_beats = 1; m_idle = 0;
            end
        end else if (m_wr_en && !m_closing) begin
            want = m_start + 32'(4 * m_beats);
            if (fresh && wb_adr != want) m_closing = 1'b1;
            else if (fresh && !fifo_full) begin took = 1'b1; m_beats++; m_idle = 0; end
            else if (fifo_full) m_idle = 0;
            else if (m_idle >= IDLE_TIMEOUT - 1) begin if (fifo_empty) m_closing = 1'b1; end
            else m_idle++;
        end else if (m_closing) begin
            if (fifo_empty) begin m_wr_en = 0; m_closing = 0; m_settling = 1; m_streak = 0; end
        end else begin
            m_streak = wr_ready ? m_streak + 1 : 0;
            if (m_streak == 2) m_settling = 1'b0;
        end
        m_ack = took;
        if (took) begin
            for (int i = 0; i < 4; i++) m_data[32+i] = !wb_sel[i];
            m_data[31:0] = wb_dat;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("wb_ack", 64'(wb_ack), 64'(m_ack));
            check("fifo_wr", 64'(fifo_wr), 64'(m_ack));
            check("wr_en", 64'(wr_en), 64'(m_wr_en));
            check("wr_address", 64'(wr_address), 64'(m_addr));
            if (m_ack) check("fifo_data", 64'(fifo_data), 64'(m_data));
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output int waited);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        waited = 0;
        do begin tick(); waited++; end while (!wb_ack && waited < 100);
        check("write_acked_within_bound", 64'(wb_ack), 64'd1);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(wb_ack), 64'd0);
        check({tag, "_fifo_wr"}, 64'(fifo_wr), 64'd0);
        check({tag, "_fifo_data"}, 64'(fifo_data), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_address"}, 64'(wr_address), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, w, age, gap, r;
        logic saw_low, busy, hold;
        logic [31:0] prev_adr;

        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single write opens a burst one cycle later.
        wb_cyc = 1; wb_stb = 1; wb_we = 1;
        wb_adr = 32'h100; wb_dat = 32'hDEADBEEF; wb_sel = 4'hF;
        tick();
        check("t1_ack", 64'(wb_ack), 64'd1);
        check("t1_fifo_wr", 64'(fifo_wr), 64'd1);
        check("t1_fifo_data", 64'(fifo_data), 64'h0DEADBEEF);
        check("t1_wr_en", 64'(wr_en), 64'd1);
        check("t1_wr_address", 64'(wr_address), 64'h080);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;

        // Idle timeout: en falls IDLE_TIMEOUT+1 cycles after the ack cycle.
        n = 0;
        while (wr_en && n < 40) begin tick(); n++; end
        check("t5_timeout_close_cycles", 64'(n), 64'(IDLE_TIMEOUT + 1));
        repeat (3) tick();

        // Sequential burst of four, acked every second cycle, one start address.
        for (int i = 0; i < 4; i++) begin
            wb_write(32'h200 + 32'(4 * i), $urandom, 4'hF, w);
            check("t2_ack_latency", 64'(w), (i == 0) ? 64'd1 : 64'd2);
            check("t2_wr_address", 64'(wr_address), 64'h100);
        end

        // Address break: not acked while draining, replayed after release.
        fifo_empty = 0;
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h400; wb_dat = 32'hCAFEF00D; wb_sel = 4'hF;
        repeat (4) begin
            tick();
            check("t3_break_no_ack", 64'(wb_ack), 64'd0);
        end
        check("t3_drain_holds_en", 64'(wr_en), 64'd1);
        fifo_empty = 1;
        saw_low = 0; n = 0;
        do begin tick(); n++; if (!wr_en) saw_low = 1; end while (!wb_ack && n < 20);
        check("t3_en_dropped", 64'(saw_low), 64'd1);
        check("t3_replay_ack", 64'(wb_ack), 64'd1);
        check("t3_wr_address", 64'(wr_address), 64'h200);

        // Byte masks and FIFO-full stall inside the open burst.
        wb_adr = 32'h404; wb_dat = 32'h11223344; wb_sel = 4'b0110;
        tick();
        fifo_full = 1;
        repeat (5) begin
            tick();
            check("t4_full_no_ack", 64'(wb_ack), 64'd0);
        end
        fifo_full = 0;
        tick();
        check("t4_ack_after_full", 64'(wb_ack), 64'd1);
        check("t4_fifo_data", 64'(fifo_data), 64'h911223344);
        check("t4_burst_open", 64'(wr_en), 64'd1);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;

        // Asynchronous reset mid-burst.
        rst_n = 0;
        #1;
        check_all_zero("t5_async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the model.
        prev_adr = 32'h1000; busy = 0; gap = 0; age = 0; hold = 0;
        for (int c = 0; c < 3000; c++) begin
            fifo_full  = ($urandom_range(0, 7) == 0);
            fifo_empty = ($urandom_range(0, 3) != 0);
            wr_ready   = ($urandom_range(0, 7) != 0);
            hold = 0;
            if (busy && wb_ack) begin
                busy = 0; prev_adr = wb_adr;
                hold = ($urandom_range(0, 1) == 1);
            end
            if (!busy && !hold) begin
                if (gap > 0) begin
                    gap--;
                    wb_we = 0; wb_cyc = ($urandom_range(0, 1) == 1); wb_stb = wb_cyc;
                    wb_adr = $urandom;
                end else begin
                    busy = 1; age = 0;
                    wb_cyc = 1; wb_stb = 1; wb_we = 1;
                    r = $urandom_range(0, 9);
                    wb_adr = (r < 7) ? prev_adr + 32'd4 : ($urandom & 32'hFFFF_FFFC);
                    wb_dat = $urandom; wb_sel = 4'($urandom);
                    r = $urandom_range(0, 15);
                    gap = (r == 0) ? $urandom_range(18, 30) : ((r < 6) ? $urandom_range(1, 3) : 0);
                end
            end
            if (busy) begin
                age++;
                if (age > 300) begin
                    check("random_ack_wait_bound", 64'(age), 64'd300);
                    busy = 0;
                end
            end
            tick();
        end

        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
